// File: rtl/pc_unit.sv
// Fetch program counter for the DLX IF stage: sequential step, prioritised
// exception/branch redirect, stall hold and a circular return-address stack.
module pc_unit #(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_PC  = 32'h00400000,
  parameter logic [WIDTH-1:0]  EXC_PC    = 32'h80000180,
  parameter int                INC       = 4,
  parameter int                RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             exc,
  input  logic             Branch,
  input  logic [WIDTH-1:0] BranchPC,
  input  logic             call,
  input  logic [WIDTH-1:0] ret_addr,
  input  logic             ret,
  output logic [WIDTH-1:0] PC,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ret_miss
);

  localparam int              PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int              CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] rasMem [RAS_DEPTH];
  logic [PTR_W-1:0] topPtr;
  logic [PTR_W-1:0] pushPtr;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] seqPC;
  logic             retLive;
  logic             doPush;
  logic             doPop;
  logic             doMiss;

  assign seqPC   = PC + WIDTH'(INC);
  assign pushPtr = topPtr + PTR_W'(1);

  // A ret only acts when no higher-priority redirect claims the cycle.
  assign retLive = ret && !exc && !Branch && !stall;
  assign doPush  = !exc && Branch && call;
  assign doPop   = retLive && (count != '0);
  assign doMiss  = retLive && (count == '0);

  assign ras_empty = (count == '0);
  assign ras_full  = (count == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      PC       <= RESET_PC;
      count    <= '0;
      topPtr   <= '0;
      ret_miss <= 1'b0;
    end else begin
      ret_miss <= doMiss;
      if (exc) begin
        PC    <= EXC_PC;
        count <= '0;
      end else if (Branch) begin
        PC <= BranchPC;
        if (call) begin
          topPtr <= pushPtr;
          if (count != CNT_MAX) count <= count + CNT_W'(1);
        end
      end else if (doPop) begin
        PC     <= rasMem[topPtr];
        topPtr <= topPtr - PTR_W'(1);
        count  <= count - CNT_W'(1);
      end else if (!stall) begin
        PC <= seqPC;
      end
    end
  end

  // Push on a full stack lands on the oldest slot, so overwrite is implicit.
  always_ff @(posedge clk) begin
    if (!reset && doPush) rasMem[pushPtr] <= ret_addr;
  end

endmodule
